// File: rtl/ldpc_cnu_minsum_if.sv
// ldpc_cnu_minsum_if
// Handshake bundle for the min-sum check-node unit.
//   Input side : i_data, i_val, i_last (to CNU), i_rdy (from CNU)
//   Output side: o_data, o_idx, o_val, o_last, o_ovf (from CNU), o_rdy (to CNU)
// master = message source/sink (variable-node side), slave = the CNU.
interface ldpc_cnu_minsum_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic [WIDTH-1:0] i_data;
    logic             i_val;
    logic             i_last;
    logic             i_rdy;
    logic [WIDTH-1:0] o_data;
    logic [IDX_W-1:0] o_idx;
    logic             o_val;
    logic             o_last;
    logic             o_rdy;
    logic             o_ovf;

    modport master (
        output i_data, i_val, i_last, o_rdy,
        input  i_rdy, o_data, o_idx, o_val, o_last, o_ovf
    );

    modport slave (
        input  i_data, i_val, i_last, o_rdy,
        output i_rdy, o_data, o_idx, o_val, o_last, o_ovf
    );
endinterface

// File: rtl/ldpc_cnu_minsum.sv
// ldpc_cnu_minsum
// Min-sum check-node unit. Collects up to DEG_MAX V2C messages for one
// parity row (tracking min1, min2, idx1, total sign, per-edge signs), then
// streams one extrinsic C2V message per edge in arrival order.
// Ports:
//   clk   - clock
//   xrst  - asynchronous active-low reset
//   bus   - ldpc_cnu_minsum_if.slave (input beats in, C2V messages out,
//           o_ovf pulse when a row is forced closed at DEG_MAX edges)
// Build option: define CNU_OFFSET_EN for offset min-sum (magnitude reduced
// by OFFSET and floored at 0); otherwise plain min-sum.
//
// State   | meaning
// COLLECT | accepting V2C beats of a row (i_rdy=1)
// EMIT    | streaming C2V messages, edge r_k (o_val=1)
module ldpc_cnu_minsum #(
    parameter int WIDTH   = 8,
    parameter int DEG_MAX = 8,
    parameter int IDX_W   = 3,
    parameter int OFFSET  = 1
) (
    input logic                  clk,
    input logic                  xrst,
    ldpc_cnu_minsum_if.slave     bus
);
    localparam int CW = IDX_W + 1;
    localparam logic [WIDTH-1:0] MAXMAG  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OFF     = WIDTH'(OFFSET);
`ifdef CNU_OFFSET_EN
    localparam bit OFF_EN = 1'b1;
`else
    localparam bit OFF_EN = 1'b0;
`endif

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_deg;
    logic [IDX_W-1:0]      r_k;
    logic [IDX_W-1:0]      r_idx1;
    logic [WIDTH-1:0]      r_min1;
    logic [WIDTH-1:0]      r_min2;
    logic                  r_tsign;
    logic [(1<<IDX_W)-1:0] r_sgn;
    logic                  r_last;
    logic                  r_ovf;

    logic             w_sign;
    logic [WIDTH-1:0] w_neg;
    logic [WIDTH-1:0] w_mag;
    logic             w_acc;
    logic             w_first;
    logic             w_close;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_mo;
    logic             w_osign;
    logic [WIDTH-1:0] w_data;

    assign w_sign  = bus.i_data[WIDTH-1];
    assign w_neg   = (~bus.i_data) + {{(WIDTH-1){1'b0}}, 1'b1};
    // The most negative input has no positive counterpart; clamp to MAXMAG.
    assign w_mag   = !w_sign ? bus.i_data :
                     (bus.i_data == MOSTNEG) ? MAXMAG : w_neg;
    assign w_acc   = bus.i_val && (r_state == COLLECT);
    assign w_first = (r_cnt == '0);
    assign w_close = bus.i_last || (r_cnt == CW'(DEG_MAX - 1));

    // Extrinsic magnitude: the edge holding min1 gets min2, all others min1.
    assign w_m     = (r_k == r_idx1) ? r_min2 : r_min1;
    assign w_mo    = !OFF_EN ? w_m : ((w_m > OFF) ? (w_m - OFF) : '0);
    assign w_osign = r_tsign ^ r_sgn[r_k];
    assign w_data  = w_osign ? ((~w_mo) + {{(WIDTH-1){1'b0}}, 1'b1}) : w_mo;

    assign bus.i_rdy  = (r_state == COLLECT);
    assign bus.o_val  = (r_state == EMIT);
    assign bus.o_data = (r_state == EMIT) ? w_data : '0;
    assign bus.o_idx  = r_k;
    assign bus.o_last = r_last;
    assign bus.o_ovf  = r_ovf;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_deg   <= '0;
            r_k     <= '0;
            r_idx1  <= '0;
            r_min1  <= MAXMAG;
            r_min2  <= MAXMAG;
            r_tsign <= 1'b0;
            r_sgn   <= '0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_acc) begin
                        r_sgn[r_cnt[IDX_W-1:0]] <= w_sign;
                        if (w_first) begin
                            r_min1  <= w_mag;
                            r_min2  <= MAXMAG;
                            r_idx1  <= '0;
                            r_tsign <= w_sign;
                        end else begin
                            r_tsign <= r_tsign ^ w_sign;
                            if (w_mag < r_min1) begin
                                r_min2 <= r_min1;
                                r_min1 <= w_mag;
                                r_idx1 <= r_cnt[IDX_W-1:0];
                            end else if (w_mag < r_min2) begin
                                r_min2 <= w_mag;
                            end
                        end
                        if (w_close) begin
                            r_state <= EMIT;
                            r_deg   <= r_cnt + CW'(1);
                            r_k     <= '0;
                            r_last  <= w_first;
                            r_ovf   <= !bus.i_last;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (bus.o_rdy) begin
                        if (r_last) begin
                            r_state <= COLLECT;
                            r_last  <= 1'b0;
                            r_k     <= '0;
                        end else begin
                            r_k    <= r_k + IDX_W'(1);
                            // next edge is last when k+1 == deg-1
                            r_last <= (({1'b0, r_k} + CW'(2)) == r_deg);
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_cnu_minsum.sv
module tb_ldpc_cnu_minsum;
    logic clk;
    logic xrst;
    int   checks;
    int   failures;

    ldpc_cnu_minsum_if #(.WIDTH(8), .IDX_W(3)) bus ();

    ldpc_cnu_minsum #(.WIDTH(8), .DEG_MAX(8), .IDX_W(3), .OFFSET(1)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] stim [0:7];
    logic signed [7:0] cap_data [0:15];
    logic [2:0]        cap_idx  [0:15];
    logic              cap_last [0:15];
    int                cap_n;
    int                cap_ovf;
    int                cap_to;
    int                cap_cyc;

    // Drive n beats from stim[]; i_last on the final beat if with_last.
    // Returns at the negedge after the closing beat was taken.
    task automatic send_row(input int n, input bit with_last);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            bus.i_val  = 1'b1;
            bus.i_data = stim[b];
            bus.i_last = with_last && (b == n - 1);
        end
        @(negedge clk);
        bus.i_val  = 1'b0;
        bus.i_last = 1'b0;
        bus.i_data = '0;
    endtask

    // Records output transfers (o_rdy high) until o_last or max_n; bounded.
    task automatic capture(input int max_n);
        cap_n = 0; cap_ovf = 0; cap_to = 1; cap_cyc = 0;
        bus.o_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_ovf) cap_ovf++;
            if (bus.o_val && bus.o_rdy) begin
                cap_data[cap_n] = bus.o_data;
                cap_idx[cap_n]  = bus.o_idx;
                cap_last[cap_n] = bus.o_last;
                cap_n++;
                if (bus.o_last || cap_n == max_n) begin
                    cap_to  = 0;
                    cap_cyc = c + 1;
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.i_rdy !== 1'b1) begin failures++; $display("FAIL reset_i_rdy got=%b exp=1", bus.i_rdy); end
        checks++; if (bus.o_val !== 1'b0) begin failures++; $display("FAIL reset_o_val got=%b exp=0", bus.o_val); end
        checks++; if (bus.o_data !== 8'd0) begin failures++; $display("FAIL reset_o_data got=%0d exp=0", bus.o_data); end
        checks++; if (bus.o_idx !== 3'd0) begin failures++; $display("FAIL reset_o_idx got=%0d exp=0", bus.o_idx); end
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL reset_o_last got=%b exp=0", bus.o_last); end
        checks++; if (bus.o_ovf !== 1'b0) begin failures++; $display("FAIL reset_o_ovf got=%b exp=0", bus.o_ovf); end
    endtask

    task automatic test_basic();
        int exp_d [4] = '{2, -2, 2, -3};
        stim[0] = 5; stim[1] = -3; stim[2] = 7; stim[3] = -2;
        bus.o_rdy = 1'b1;
        send_row(4, 1'b1);
        checks++; if (bus.o_val !== 1'b1 || bus.o_idx !== 3'd0) begin failures++; $display("FAIL basic_first_out o_val=%b o_idx=%0d exp 1/0", bus.o_val, bus.o_idx); end
        checks++; if (bus.i_rdy !== 1'b0) begin failures++; $display("FAIL basic_i_rdy_emit got=%b exp=0", bus.i_rdy); end
        capture(4);
        checks++; if (cap_to !== 0 || cap_n !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4 timeout=%0d", cap_n, cap_to); end
        checks++; if (cap_cyc !== 4) begin failures++; $display("FAIL basic_throughput cycles=%0d exp=4", cap_cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(cap_data[i]) !== exp_d[i] || cap_idx[i] !== 3'(i) || cap_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_edge[%0d] data=%0d idx=%0d last=%b exp data=%0d idx=%0d last=%b",
                         i, cap_data[i], cap_idx[i], cap_last[i], exp_d[i], i, (i == 3));
            end
        end
        checks++; if (bus.i_rdy !== 1'b0) begin failures++; $display("FAIL basic_i_rdy_at_last got=%b exp=0", bus.i_rdy); end
        @(negedge clk);
        checks++; if (bus.i_rdy !== 1'b1 || bus.o_val !== 1'b0) begin failures++; $display("FAIL basic_return i_rdy=%b o_val=%b exp 1/0", bus.i_rdy, bus.o_val); end
    endtask

    task automatic test_tie();
        int exp_d [3] = '{-4, 4, -4};
        stim[0] = 4; stim[1] = -4; stim[2] = 6;
        send_row(3, 1'b1);
        capture(3);
        checks++; if (cap_to !== 0 || cap_n !== 3) begin failures++; $display("FAIL tie_count got=%0d exp=3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (int'(cap_data[i]) !== exp_d[i]) begin failures++; $display("FAIL tie_edge[%0d] got=%0d exp=%0d", i, cap_data[i], exp_d[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        stim[0] = -128; stim[1] = 9;
        send_row(2, 1'b1);
        capture(2);
        checks++; if (int'(cap_data[0]) !== 9) begin failures++; $display("FAIL sat_edge0 got=%0d exp=9", cap_data[0]); end
        checks++; if (int'(cap_data[1]) !== -127 || cap_last[1] !== 1'b1) begin failures++; $display("FAIL sat_edge1 got=%0d last=%b exp=-127 last=1", cap_data[1], cap_last[1]); end
        @(negedge clk);
        stim[0] = 9;
        send_row(1, 1'b1);
        capture(1);
        checks++; if (cap_n !== 1 || int'(cap_data[0]) !== 127 || cap_last[0] !== 1'b1 || cap_idx[0] !== 3'd0) begin
            failures++; $display("FAIL deg1_out n=%0d got=%0d last=%b idx=%0d exp 1/127/1/0", cap_n, cap_data[0], cap_last[0], cap_idx[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        stim[0] = 5; stim[1] = -3; stim[2] = 7; stim[3] = -2;
        bus.o_rdy = 1'b1;
        send_row(4, 1'b1);
        @(negedge clk);
        bus.o_rdy = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks++;
            if (bus.o_val !== 1'b1 || bus.o_data !== 8'hFE || bus.o_idx !== 3'd1 || bus.i_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] val=%b data=%0d idx=%0d i_rdy=%b exp 1/-2/1/0", h, bus.o_val, $signed(bus.o_data), bus.o_idx, bus.i_rdy);
            end
        end
        capture(4);
        checks++; if (cap_n !== 3 || int'(cap_data[0]) !== -2 || int'(cap_data[1]) !== 2 || int'(cap_data[2]) !== -3 || cap_idx[2] !== 3'd3) begin
            failures++; $display("FAIL bp_rest n=%0d d=%0d,%0d,%0d idx_last=%0d exp 3 -2,2,-3 idx 3", cap_n, cap_data[0], cap_data[1], cap_data[2], cap_idx[2]);
        end
        checks++; if (bus.i_rdy !== 1'b0) begin failures++; $display("FAIL bp_i_rdy_early got=%b exp=0", bus.i_rdy); end
        @(negedge clk);
        checks++; if (bus.i_rdy !== 1'b1) begin failures++; $display("FAIL bp_i_rdy_after got=%b exp=1", bus.i_rdy); end
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 8; b++) stim[b] = 8'(b + 1);
        send_row(8, 1'b0);
        checks++; if (bus.o_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", bus.o_ovf); end
        capture(8);
        checks++; if (cap_ovf !== 1) begin failures++; $display("FAIL ovf_width cycles=%0d exp=1", cap_ovf); end
        checks++; if (cap_n !== 8 || cap_idx[7] !== 3'd7 || cap_last[7] !== 1'b1 || cap_last[6] !== 1'b0) begin
            failures++; $display("FAIL ovf_last n=%0d idx=%0d last7=%b last6=%b exp 8/7/1/0", cap_n, cap_idx[7], cap_last[7], cap_last[6]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (int'(cap_data[i]) !== ((i == 0) ? 2 : 1)) begin failures++; $display("FAIL ovf_edge[%0d] got=%0d exp=%0d", i, cap_data[i], (i == 0) ? 2 : 1); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_emit();
        stim[0] = 5; stim[1] = -3; stim[2] = 7; stim[3] = -2;
        bus.o_rdy = 1'b1;
        send_row(4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        xrst = 1'b0;
        #1;
        checks++; if (bus.o_val !== 1'b0 || bus.i_rdy !== 1'b1 || bus.o_data !== 8'd0) begin
            failures++; $display("FAIL rst_mid o_val=%b i_rdy=%b o_data=%0d exp 0/1/0", bus.o_val, bus.i_rdy, bus.o_data);
        end
        @(negedge clk);
        xrst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus.o_val !== 1'b0) begin failures++; $display("FAIL rst_no_output o_val=%b exp=0", bus.o_val); end
        end
        stim[0] = 3; stim[1] = 5;
        send_row(2, 1'b1);
        capture(2);
        checks++; if (cap_n !== 2 || int'(cap_data[0]) !== 5 || int'(cap_data[1]) !== 3) begin
            failures++; $display("FAIL rst_next_row n=%0d d=%0d,%0d exp 2 5,3", cap_n, cap_data[0], cap_data[1]);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        xrst = 1'b0;
        bus.i_data = '0; bus.i_val = 1'b0; bus.i_last = 1'b0; bus.o_rdy = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        xrst = 1'b1;
        @(negedge clk);
        test_basic();
        test_tie();
        test_saturation();
        test_backpressure();
        test_overflow();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ldpc_cnu_minsum.md
# ldpc_cnu_minsum

Parametrised min-sum check-node unit for the LDPC decoder. It replaces the single-output row minimum/sign accumulator with a full extrinsic check-node processor. It collects up to DEG_MAX variable-to-check messages for one parity row and tracks min1, min2, the index of min1, the total sign and the per-edge signs. It then streams one extrinsic check-to-variable message per edge back to the variable-node side under a valid/ready handshake.

## Interface
- WIDTH, 8: message width, two's complement signed
- DEG_MAX, 8: maximum row weight (edges per row), ≥2
- IDX_W, 3: edge index width, ≥ clog2(DEG_MAX)
- OFFSET, 1: offset-min-sum beta; used only with CNU_OFFSET_EN
- clk  in  1  clock
- xrst  in  1  reset, asynchronous, active-low
- i_data  in  WIDTH  incoming V2C message
- i_val  in  1  input valid
- i_last  in  1  marks last edge of the row
- i_rdy  out  1  unit accepts input (COLLECT state)
- o_data  out  WIDTH  extrinsic C2V message, two's complement
- o_idx  out  IDX_W  edge index of o_data (0-based, arrival order)
- o_val  out  1  output valid
- o_last  out  1  marks last output of the row
- o_rdy  in  1  downstream accepts output
- o_ovf  out  1  one-cycle pulse: row forced closed at DEG_MAX edges

## Operation
- States: COLLECT (i_rdy=1, o_val=0) and EMIT (i_rdy=0, o_val=1).
- Input beat accepted when i_val && i_rdy. Per beat:
  - sign s = i_data[WIDTH-1];
  - mag = |i_data|, with -2^(WIDTH-1) saturated to 2^(WIDTH-1)-1 (MAXMAG);
  - sgn_buf[cnt] <= s; tsign ^= s.
- First beat of a row initialises: min1=mag, idx1=0, min2=MAXMAG, tsign=s, cnt=1.
- Later beats: if mag < min1 then min2<=min1, min1<=mag, idx1<=cnt; else if mag < min2 then min2<=mag. A tie with min1 therefore sets min2=min1.
- Row closes on an accepted beat with i_last=1, or on the DEG_MAX-th beat. Forced close without i_last pulses o_ovf. deg<=cnt+1; state goes to EMIT, k=0.
- EMIT, edge k:
  - magnitude m = (k==idx1) ? min2 : min1;
  - sign = tsign ^ sgn_buf[k];
  - o_data = sign ? -m : m; o_idx=k; o_last=(k==deg-1).
- Output transfer on o_val && o_rdy: k increments. After the transfer with o_last, state returns to COLLECT.
- Degree 1: the single output is ±MAXMAG, with sign = tsign ^ s = positive.
- i_val while i_rdy=0 is ignored; the source must hold data.
- Arithmetic is in WIDTH bits with no growth. The magnitude never exceeds MAXMAG, so negation never overflows.

## Timing
- Reset (asynchronous): state COLLECT, i_rdy=1, o_val=0, o_data=0, o_idx=0, o_last=0, o_ovf=0, cnt=0, min1=min2=MAXMAG, tsign=0.
- Reset mid-row or mid-emit discards the row. No output follows.
- Closing beat accepted at cycle t: o_val=1 at t+1 with edge 0, and i_rdy=0 from t+1.
- With o_rdy held high, one output per cycle: edges 0..deg-1 at t+1..t+deg.
- Last output transfer at cycle u: i_rdy=1 at u+1. There is no overlap between rows.
- o_data, o_idx and o_last are held stable while o_val && !o_rdy.
- o_ovf is high exactly during cycle t+1.

## Configuration
- CNU_OFFSET_EN defined: emitted magnitude = max(m - OFFSET, 0) (offset min-sum). Sign is applied after the offset, so a zero magnitude is output as 0.
- Undefined: plain min-sum. The OFFSET parameter is ignored and m is emitted directly.

## Test plan
- Row +5,-3,+7,-2 (i_last on 4th), o_rdy=1 -> outputs +2,-2,+2,-3 on idx 0..3, o_last on idx 3. With CNU_OFFSET_EN, OFFSET=1: +1,-1,+1,-2.
- Tie row +4,-4,+6 -> -4,+4,-4; min2 equals min1.
- Saturation: row -128,+9 (WIDTH=8) -> edge0 +9, edge1 -127; degree-1 row +9 -> +127.
- Backpressure: row +5,-3,+7,-2 with o_rdy low for 3 cycles at edge 1 -> o_data=-2, o_idx=1 held stable; i_rdy stays 0 until the cycle after edge-3 transfer.
- Overflow: 8 beats +1..+8 with no i_last (DEG_MAX=8) -> o_ovf pulse the cycle after beat 8; outputs +2, then +1 ×7; o_last on idx 7.
- Reset asserted mid-EMIT after edge 1 -> o_val=0, i_rdy=1 immediately; a next row +3,+5 yields +5,+3.
